tlul_stall_injector: RTL and testbench
======================================

Name: tlul_stall_injector

Overview:
- Random-backpressure stage on one TL-UL valid/ready channel (A or D), used for stress and verification builds.
- Consumes the output of the team's 16-bit LFSR module `lfsr`. Drives that LFSR's enable so the LFSR advances once per random decision.
- Inserts pseudo-random stall cycles between upstream and downstream without breaking valid/ready rules.
- One LFSR per injector, instantiated by the parent next to this block.

Parameters:
- DW, 32, width of the channel payload (whole packed TL-UL struct), in bits.
- STALL_PROB, 4, stall probability in sixteenths. Legal range 0..16: 0 = never stall, 16 = always stall.
- MAX_STALL_LOG2, 3, stall length is 1..2^MAX_STALL_LOG2 cycles. Legal range 1..8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- enable_i  in  1  1 = injection active; 0 = transparent
- lfsr_i  in  16  random value from `lfsr`
- lfsr_en_o  out  1  advance request to `lfsr`
- in_valid_i  in  1  upstream valid
- in_ready_o  out  1  upstream ready
- in_data_i  in  DW  upstream payload
- out_valid_o  out  1  downstream valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  DW  downstream payload (always equals in_data_i, combinational)
- clr_stats_i  in  1  synchronous clear of stall_cycles_o
- stall_cycles_o  out  32  saturating count of injected stall cycles

Behaviour:
- Reset values: state IDLE, cnt 0, stall_cycles_o 0. With in_valid_i low: out_valid_o 0, lfsr_en_o 0.
- Decision, combinational, IDLE only: stall_hit = enable_i & in_valid_i & (lfsr_i[15:12] < STALL_PROB), strict less-than. L = lfsr_i[MAX_STALL_LOG2-1:0] + 1.
- IDLE:
  - lfsr_en_o = enable_i & in_valid_i, i.e. one pulse per decision.
  - If stall_hit: out_valid_o = 0, in_ready_o = 0, cnt <= L-1. Next state is PASS if L == 1, else STALL.
  - Else: out_valid_o = in_valid_i, in_ready_o = out_ready_i (zero latency). If valid was high and not accepted, next state is PASS; otherwise stay in IDLE.
- STALL:
  - out_valid_o = 0, in_ready_o = 0, lfsr_en_o = 0.
  - cnt decrements each cycle. When cnt == 1, next state is PASS.
  - Total stall is exactly L cycles, including the decision cycle.
- PASS:
  - out_valid_o = in_valid_i, in_ready_o = out_ready_i, no new decision, lfsr_en_o = 0.
  - On handshake (in_valid_i & out_ready_i), next state is IDLE.
  - Once raised, out_valid_o stays high until accepted. The upstream is TL-UL compliant and holds valid.
- enable_i low:
  - In IDLE: pure passthrough, lfsr_en_o = 0.
  - In STALL: abort; next state PASS, cnt <= 0. This is legal because out_valid was low.
  - In PASS: no effect.
- Stats:
  - stall_cycles_o increments in every cycle where (IDLE & stall_hit) or STALL.
  - Saturates at 32'hFFFF_FFFF.
  - clr_stats_i has priority over increment: the register becomes 0 that cycle.
- Width rules: cnt is MAX_STALL_LOG2 bits wide (L-1 fits). L is computed at MAX_STALL_LOG2+1 bits.
- Reset mid-stall: immediate return to IDLE. The channel is transparent on the first cycle after reset release.
- Parameter checks by elaboration assertion: STALL_PROB <= 16, 1 <= MAX_STALL_LOG2 <= 8.

Decomposition:
- Package tlul_stall_pkg holds:
  - stall_state_e (IDLE, STALL, PASS)
  - localparam PROB_W = 4
  - localparam STAT_W = 32
- No sub-module. The `lfsr` instance lives in the parent, so one LFSR can be reused or replaced.
- Single always_ff for state/cnt/stats, single always_comb for outputs and next state.

Test Plan:
- STALL_PROB=16, MAX_STALL_LOG2=3, lfsr_i=16'h0005, in_valid_i rises at cycle 0, out_ready_i=1 -> out_valid_o 0 for cycles 0..5 and 1 at cycle 6. Handshake at 6, stall_cycles_o=6, lfsr_en_o high only at cycle 0.
- STALL_PROB=4, lfsr_i=16'h4000 (top nibble 4, not < 4) -> no stall; same-cycle passthrough, out_data_o==in_data_i. lfsr_en_o pulses once, stall_cycles_o stays 0.
- No stall, out_ready_i=0 for 3 cycles then 1 -> FSM sits in PASS, out_valid_o held high with stable data, single handshake, returns to IDLE.
- STALL_PROB=16, lfsr_i=16'h0007 (L=8); drop enable_i at cycle 3 -> STALL aborted, out_valid_o=1 at cycle 4, stall_cycles_o=4.
- Assert rst_ni low mid-STALL at cycle 2, release at cycle 4 -> all outputs at reset values during reset. Cycle 4 is transparent; stall_cycles_o=0.
- Preload stall_cycles_o near saturation by forcing it to 32'hFFFF_FFFE, then inject a 4-cycle stall -> stalls at 32'hFFFF_FFFF. clr_stats_i asserted in a stall cycle -> reads 0 next cycle.

Source files
------------

// File: rtl/tlul_stall_pkg.sv
// ============================================================================
// Module      : tlul_stall_pkg
// Description : Shared types and constants for the TL-UL stall injector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_stall_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    PASS  = 2'd2
  } stall_state_e;

  localparam int unsigned PROB_W = 4;
  localparam int unsigned STAT_W = 32;

endpackage

`default_nettype wire

// File: rtl/tlul_stall_injector.sv
// ============================================================================
// Module      : tlul_stall_injector
// Description : Pseudo-random backpressure stage for one TL-UL valid/ready
//               channel, driven by an external 16-bit LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_stall_injector
  import tlul_stall_pkg::*;
#(
  parameter int unsigned DW             = 32,
  parameter int unsigned STALL_PROB     = 4,
  parameter int unsigned MAX_STALL_LOG2 = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic [15:0]       lfsr_i,
  output logic              lfsr_en_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DW-1:0]     in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DW-1:0]     out_data_o,
  input  logic              clr_stats_i,
  output logic [STAT_W-1:0] stall_cycles_o
);

  localparam int unsigned CW = MAX_STALL_LOG2;

  // One extra bit so that STALL_PROB == 16 means "every nibble value hits".
  localparam logic [PROB_W:0] C_PROB_THR = (PROB_W + 1)'(STALL_PROB);

  if (STALL_PROB > 16) begin : g_chk_prob
    $error("tlul_stall_injector: STALL_PROB must be 0..16");
  end
  if (MAX_STALL_LOG2 < 1 || MAX_STALL_LOG2 > 8) begin : g_chk_len
    $error("tlul_stall_injector: MAX_STALL_LOG2 must be 1..8");
  end

  stall_state_e      r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [STAT_W-1:0] r_stall_cycles;
  logic              w_stall_hit;
  logic              w_stall_cyc;
  logic [CW:0]       w_len;
  logic [CW:0]       w_len_m1;
  logic              w_unused_lfsr;

  assign w_stall_hit   = enable_i & in_valid_i & ({1'b0, lfsr_i[15:12]} < C_PROB_THR);
  assign w_len         = {1'b0, lfsr_i[CW-1:0]} + (CW + 1)'(1);
  assign w_len_m1      = w_len - (CW + 1)'(1);
  assign w_unused_lfsr = ^lfsr_i[11:CW];

  assign out_data_o     = in_data_i;
  assign stall_cycles_o = r_stall_cycles;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    out_valid_o = 1'b0;
    in_ready_o  = 1'b0;
    lfsr_en_o   = 1'b0;
    w_stall_cyc = 1'b0;
    unique case (r_state)
      IDLE: begin
        lfsr_en_o = enable_i & in_valid_i;
        if (w_stall_hit) begin
          // The decision cycle itself is the first of the L stall cycles.
          w_stall_cyc = 1'b1;
          w_cnt_nxt   = w_len_m1[CW-1:0];
          w_state_nxt = (w_len_m1 == '0) ? PASS : STALL;
        end else begin
          out_valid_o = in_valid_i;
          in_ready_o  = out_ready_i;
          if (in_valid_i && !out_ready_i) begin
            w_state_nxt = PASS;
          end
        end
      end
      STALL: begin
        w_stall_cyc = 1'b1;
        if (!enable_i) begin
          w_state_nxt = PASS;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_state_nxt = PASS;
          end
        end
      end
      PASS: begin
        out_valid_o = in_valid_i;
        in_ready_o  = out_ready_i;
        if (in_valid_i && out_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (clr_stats_i) begin
        r_stall_cycles <= '0;
      end else if (w_stall_cyc && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + STAT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tlul_stall_injector.sv
// ============================================================================
// Module      : tb_tlul_stall_injector
// Description : Self-checking bench for tlul_stall_injector (vector table,
//               handwritten corner sequences, payload scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlul_stall_injector;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          enable_i;
  logic [15:0]   lfsr_i;
  logic          lfsr_en_o;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          clr_stats_i;
  logic [31:0]   stall_cycles_o;

  always #5 clk_i = ~clk_i;

  tlul_stall_injector #(
    .DW(DW), .STALL_PROB(4), .MAX_STALL_LOG2(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .lfsr_i(lfsr_i),
    .lfsr_en_o(lfsr_en_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .clr_stats_i(clr_stats_i),
    .stall_cycles_o(stall_cycles_o)
  );

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] sb[$];
  logic [31:0]   exp_stats;

  typedef struct {
    logic [15:0] lfsr;
    logic        en;
    int          lat;
    int          delta;
    int          pulses;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int d);
    logic [32:0] s;
    s = {1'b0, a} + 33'(d);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Scoreboard: every accepted downstream beat must match the oldest driven payload.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) chk("sb_unexpected_beat", out_data_o, 32'hxxxx_xxxx);
      else chk("sb_data", out_data_o, sb.pop_front());
    end
  end

  task automatic run_txn(input logic [15:0] lfsr, input logic en, input logic [DW-1:0] data,
                         output int lat, output int pulses);
    lfsr_i = lfsr; enable_i = en; in_data_i = data;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    sb.push_back(data);
    lat = -1; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (lfsr_en_o) pulses++;
      if (out_valid_o) begin lat = c; break; end
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  int lat, pulses;

  initial begin
    vecs[0] = '{16'h0005, 1'b1, 6, 6, 1};
    vecs[1] = '{16'h4000, 1'b1, 0, 0, 1};
    vecs[2] = '{16'h3000, 1'b1, 1, 1, 1};
    vecs[3] = '{16'hF007, 1'b1, 0, 0, 1};
    vecs[4] = '{16'h0007, 1'b0, 0, 0, 0};
    vecs[5] = '{16'h2001, 1'b1, 2, 2, 1};
    vecs[6] = '{16'h1007, 1'b1, 8, 8, 1};

    rst_ni = 1'b0; enable_i = 1'b1; lfsr_i = 16'h0; in_valid_i = 1'b0;
    in_data_i = '0; out_ready_i = 1'b1; clr_stats_i = 1'b0;
    exp_stats = 32'h0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_lfsr_en", 32'(lfsr_en_o), 32'h0);
    chk("rst_stats", stall_cycles_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].lfsr, vecs[i].en, 32'hA000_0000 + 32'(i), lat, pulses);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_lfsr_pulses", i), 32'(pulses), 32'(vecs[i].pulses));
      exp_stats = sat_add(exp_stats, vecs[i].delta);
      chk($sformatf("vec%0d_stats", i), stall_cycles_o, exp_stats);
    end

    // Downstream backpressure: beat must be held stable in PASS.
    lfsr_i = 16'hF000; enable_i = 1'b1; in_data_i = 32'h5EED_0001;
    in_valid_i = 1'b1; out_ready_i = 1'b0; sb.push_back(32'h5EED_0001);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk($sformatf("bp_valid_c%0d", c), 32'(out_valid_o), 32'h1);
      chk($sformatf("bp_ready_c%0d", c), 32'(in_ready_o), 32'h0);
      chk($sformatf("bp_data_c%0d", c), out_data_o, 32'h5EED_0001);
      chk($sformatf("bp_lfsr_en_c%0d", c), 32'(lfsr_en_o), (c == 0) ? 32'h1 : 32'h0);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_valid_accept", 32'(out_valid_o), 32'h1);
    chk("bp_ready_accept", 32'(in_ready_o), 32'h1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    chk("bp_stats", stall_cycles_o, exp_stats);

    // Abort of an 8-cycle stall by dropping enable in cycle 3.
    lfsr_i = 16'h0007; enable_i = 1'b1; in_data_i = 32'hAB0A_0003;
    in_valid_i = 1'b1; sb.push_back(32'hAB0A_0003);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) enable_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("abort_valid_c%0d", c), 32'(out_valid_o), 32'h0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("abort_valid_c4", 32'(out_valid_o), 32'h1);
    chk("abort_lfsr_en_c4", 32'(lfsr_en_o), 32'h0);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; enable_i = 1'b1;
    exp_stats = sat_add(exp_stats, 4);
    chk("abort_stats", stall_cycles_o, exp_stats);

    // Asynchronous reset in the middle of a stall.
    lfsr_i = 16'h0005; in_data_i = 32'hDEAD_0000; in_valid_i = 1'b1;
    repeat (2) begin
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b0; in_valid_i = 1'b0;
    for (int c = 2; c < 4; c++) begin
      @(negedge clk_i);
      chk($sformatf("midrst_valid_c%0d", c), 32'(out_valid_o), 32'h0);
      chk($sformatf("midrst_lfsr_en_c%0d", c), 32'(lfsr_en_o), 32'h0);
      chk($sformatf("midrst_stats_c%0d", c), stall_cycles_o, 32'h0);
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b1; lfsr_i = 16'hF000; in_data_i = 32'h0C0F_FEE0;
    in_valid_i = 1'b1; sb.push_back(32'h0C0F_FEE0);
    @(negedge clk_i);
    chk("postrst_valid", 32'(out_valid_o), 32'h1);
    chk("postrst_ready", 32'(in_ready_o), 32'h1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    exp_stats = 32'h0;
    chk("postrst_stats", stall_cycles_o, exp_stats);

    // Saturation of the stall counter, then clear during a stall.
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    @(negedge clk_i);
    release dut.r_stall_cycles;
    @(posedge clk_i); #1;
    exp_stats = 32'hFFFF_FFFE;
    chk("sat_preload", stall_cycles_o, exp_stats);
    run_txn(16'h0003, 1'b1, 32'h5A70_0004, lat, pulses);
    chk("sat_latency", 32'(lat), 32'd4);
    exp_stats = sat_add(exp_stats, 4);
    chk("sat_stats", stall_cycles_o, exp_stats);

    lfsr_i = 16'h0007; in_data_i = 32'hC1EA_0008; in_valid_i = 1'b1;
    sb.push_back(32'hC1EA_0008);
    @(posedge clk_i); #1;
    clr_stats_i = 1'b1;
    @(posedge clk_i); #1;
    clr_stats_i = 1'b0;
    chk("clr_stats", stall_cycles_o, 32'h0);
    lat = -1;
    for (int c = 2; c < 20; c++) begin
      @(negedge clk_i);
      if (out_valid_o) begin lat = c; break; end
      @(posedge clk_i); #1;
    end
    chk("clr_latency", 32'(lat), 32'd8);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    exp_stats = 32'd6;
    chk("clr_stats_after", stall_cycles_o, exp_stats);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
